dft_pingpong_ctrl: RTL and testbench



---
 rtl/dft_ctrl_pkg.sv | 21 ++
 rtl/dft_lane_state.sv | 75 +++++++
 rtl/dft_pingpong_ctrl.sv | 142 ++++++++++++++
 tb/tb_dft_pingpong_ctrl.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dft_ctrl_pkg.sv
// Shared types and constants for the DFT ping-pong scheduler.
package dft_ctrl_pkg;

  localparam int W_PTS     = 12;
  localparam int NUM_LANES = 2;

  typedef enum logic [1:0] {
    LANE_EMPTY = 2'd0,
    LANE_FILL  = 2'd1,
    LANE_PROC  = 2'd2
  } lane_state_e;

  // Place a single strobe on the selected lane; every other lane reads 0.
  function automatic logic [NUM_LANES-1:0] steer(input logic sel, input logic val);
    logic [NUM_LANES-1:0] r_vec;
    r_vec      = '0;
    r_vec[sel] = val;
    return r_vec;
  endfunction

endpackage

// File: rtl/dft_lane_state.sv
// Per-lane frame state (EMPTY -> FILL -> PROC -> EMPTY) and latched DFT size.
module dft_lane_state
  import dft_ctrl_pkg::*;
#(
  parameter int W_PTS = dft_ctrl_pkg::W_PTS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,    // accepted sop for this lane: latch size
  input  logic              i_commit,   // accepted eop closes the frame
  input  logic              i_release,  // output eop drained the frame
  input  logic [W_PTS-1:0]  i_dftpts,
  output lane_state_e       o_state,
  output logic [W_PTS-1:0]  o_dftpts
);

  lane_state_e       r_state;
  lane_state_e       w_state_nxt;
  logic [W_PTS-1:0]  r_dftpts;

  // Lane state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= LANE_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: a sop+eop beat in EMPTY goes straight to PROC.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      LANE_EMPTY: begin
        if (i_commit) begin
          w_state_nxt = LANE_PROC;
        end else if (i_start) begin
          w_state_nxt = LANE_FILL;
        end else begin
          w_state_nxt = LANE_EMPTY;
        end
      end
      LANE_FILL: begin
        if (i_commit) begin
          w_state_nxt = LANE_PROC;
        end else begin
          w_state_nxt = LANE_FILL;
        end
      end
      LANE_PROC: begin
        if (i_release) begin
          w_state_nxt = LANE_EMPTY;
        end else begin
          w_state_nxt = LANE_PROC;
        end
      end
      default: w_state_nxt = LANE_EMPTY;
    endcase
  end

  // Frame size is captured on every accepted sop, including restarts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dftpts <= '0;
    end else if (i_start) begin
      r_dftpts <= i_dftpts;
    end else begin
      r_dftpts <= r_dftpts;
    end
  end

  assign o_state  = r_state;
  assign o_dftpts = r_dftpts;

endmodule

// File: rtl/dft_pingpong_ctrl.sv
// Ping-pong scheduler: steers input frames into two DFT lanes and releases
// the lane outputs in the same order the frames arrived.
module dft_pingpong_ctrl
  import dft_ctrl_pkg::*;
#(
  parameter int W_PTS = dft_ctrl_pkg::W_PTS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sink_valid,
  input  logic                  sink_sop,
  input  logic                  sink_eop,
  input  logic [W_PTS-1:0]      dftpts_in,
  output logic                  sink_ready,
  output logic                  sw_in,
  output logic [NUM_LANES-1:0]  lane_valid,
  output logic [NUM_LANES-1:0]  lane_sop,
  output logic [NUM_LANES-1:0]  lane_eop,
  output logic [W_PTS-1:0]      lane_dftpts_0,
  output logic [W_PTS-1:0]      lane_dftpts_1,
  input  logic [NUM_LANES-1:0]  lane_out_valid,
  input  logic [NUM_LANES-1:0]  lane_out_eop,
  input  logic                  source_ready,
  output logic [NUM_LANES-1:0]  lane_source_ready,
  output logic                  sw_out,
  output logic                  source_valid,
  output logic [W_PTS-1:0]      dftpts_out,
  output logic                  frame_err
);

  // One extra bit so an oversize frame cannot wrap onto a matching size.
  localparam int CNT_W = W_PTS + 1;

  logic                  r_sw_in;
  logic                  r_sw_out;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_frame_err;

  lane_state_e           w_state  [NUM_LANES];
  logic [W_PTS-1:0]      w_dftpts [NUM_LANES];
  logic [NUM_LANES-1:0]  w_start;
  logic [NUM_LANES-1:0]  w_commit;
  logic [NUM_LANES-1:0]  w_release;

  logic                  w_acc;
  logic                  w_in_fill;
  logic                  w_in_empty;
  logic                  w_fwd;
  logic                  w_start_any;
  logic                  w_commit_any;
  logic                  w_rel_any;
  logic [CNT_W-1:0]      w_cnt_eop;
  logic [W_PTS-1:0]      w_size_ref;
  logic                  w_len_err;
  logic                  w_restart_err;
  logic                  w_drop_err;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    dft_lane_state #(.W_PTS(W_PTS)) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_start   (w_start[g]),
      .i_commit  (w_commit[g]),
      .i_release (w_release[g]),
      .i_dftpts  (dftpts_in),
      .o_state   (w_state[g]),
      .o_dftpts  (w_dftpts[g])
    );
  end

  // Input side: a beat is forwarded when it opens a frame or continues one.
  assign sink_ready   = (w_state[r_sw_in] != LANE_PROC);
  assign w_acc        = sink_valid & sink_ready;
  assign w_in_fill    = (w_state[r_sw_in] == LANE_FILL);
  assign w_in_empty   = (w_state[r_sw_in] == LANE_EMPTY);
  assign w_fwd        = w_acc & (sink_sop | w_in_fill);
  assign w_start_any  = w_acc & sink_sop;
  assign w_commit_any = w_fwd & sink_eop;

  assign lane_valid   = steer(r_sw_in, w_fwd);
  assign lane_sop     = steer(r_sw_in, w_fwd & sink_sop);
  assign lane_eop     = steer(r_sw_in, w_fwd & sink_eop);
  assign w_start      = steer(r_sw_in, w_start_any);
  assign w_commit     = steer(r_sw_in, w_commit_any);

  // Output side: only the lane under sw_out is observed or released.
  assign w_rel_any         = lane_out_valid[r_sw_out] & lane_out_eop[r_sw_out] &
                             source_ready & (w_state[r_sw_out] == LANE_PROC);
  assign w_release         = steer(r_sw_out, w_rel_any);
  assign lane_source_ready = steer(r_sw_out, source_ready);
  assign source_valid      = lane_out_valid[r_sw_out];
  assign dftpts_out        = w_dftpts[r_sw_out];
  assign lane_dftpts_0     = w_dftpts[0];
  assign lane_dftpts_1     = w_dftpts[1];

  // Length check counts the eop beat; a sop+eop beat is a one-beat frame.
  assign w_cnt_eop     = sink_sop ? CNT_W'(1) : (r_cnt + CNT_W'(1));
  assign w_size_ref    = sink_sop ? dftpts_in : w_dftpts[r_sw_in];
  assign w_len_err     = w_commit_any & (w_cnt_eop != {1'b0, w_size_ref});
  assign w_restart_err = w_acc & sink_sop & w_in_fill;
  assign w_drop_err    = w_acc & ~sink_sop & w_in_empty;

  // Lane selects advance once per committed / released frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sw_in  <= 1'b0;
      r_sw_out <= 1'b0;
    end else begin
      r_sw_in  <= r_sw_in ^ w_commit_any;
      r_sw_out <= r_sw_out ^ w_rel_any;
    end
  end

  // Shared beat counter for the frame currently being filled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_commit_any) begin
      r_cnt <= '0;
    end else if (w_start_any) begin
      r_cnt <= CNT_W'(1);
    end else if (w_fwd) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  // Registered error pulse, one cycle after the offending beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= w_len_err | w_restart_err | w_drop_err;
    end
  end

  assign sw_in     = r_sw_in;
  assign sw_out    = r_sw_out;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_dft_pingpong_ctrl.sv
// Directed, table-driven bench for the DFT ping-pong scheduler.
module tb_dft_pingpong_ctrl;

  localparam int W = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sink_valid = 1'b0, sink_sop = 1'b0, sink_eop = 1'b0;
  logic [W-1:0]  dftpts_in = '0;
  logic          sink_ready, sw_in, sw_out, source_valid, frame_err;
  logic [1:0]    lane_valid, lane_sop, lane_eop, lane_source_ready;
  logic [W-1:0]  lane_dftpts_0, lane_dftpts_1, dftpts_out;
  logic [1:0]    lane_out_valid = 2'b00, lane_out_eop = 2'b00;
  logic          source_ready = 1'b0;

  int checks = 0;
  int errors = 0;
  int fwd_beats = 0;
  logic [1:0] last_lv, last_ls;

  always #5 clk = ~clk;

  dft_pingpong_ctrl #(.W_PTS(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .sink_valid(sink_valid), .sink_sop(sink_sop), .sink_eop(sink_eop),
    .dftpts_in(dftpts_in), .sink_ready(sink_ready), .sw_in(sw_in),
    .lane_valid(lane_valid), .lane_sop(lane_sop), .lane_eop(lane_eop),
    .lane_dftpts_0(lane_dftpts_0), .lane_dftpts_1(lane_dftpts_1),
    .lane_out_valid(lane_out_valid), .lane_out_eop(lane_out_eop),
    .source_ready(source_ready), .lane_source_ready(lane_source_ready),
    .sw_out(sw_out), .source_valid(source_valid), .dftpts_out(dftpts_out),
    .frame_err(frame_err)
  );

  typedef struct {
    logic v, s, e; logic [W-1:0] pts; logic [1:0] ov, oe; logic sr;
    logic rdy, swi, swo; logic [1:0] lv, ls, le, lsr; logic srcv; logic [W-1:0] dpo; logic err;
  } vec_t;

  vec_t tbl [18];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    sink_valid = 1'b0; sink_sop = 1'b0; sink_eop = 1'b0; dftpts_in = '0;
    lane_out_valid = 2'b00; lane_out_eop = 2'b00; source_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Present one beat and hold it until accepted (bounded).
  task automatic drive_beat(input logic s, input logic e, input logic [W-1:0] pts);
    int n;
    n = 0;
    sink_valid = 1'b1; sink_sop = s; sink_eop = e; dftpts_in = pts;
    @(negedge clk);
    while (!sink_ready && n < 50) begin
      @(posedge clk); #1; @(negedge clk); n++;
    end
    if (!sink_ready) begin
      checks++; errors++;
      $display("FAIL beat_timeout: got ready 0 expected ready 1 within 50 cycles");
    end
    last_lv = lane_valid; last_ls = lane_sop;
    if (lane_valid != 2'b00) fwd_beats++;
    @(posedge clk); #1;
    sink_valid = 1'b0; sink_sop = 1'b0; sink_eop = 1'b0;
  endtask

  task automatic send_frame(input logic [W-1:0] pts, input int n);
    for (int i = 0; i < n; i++) drive_beat(i == 0, i == n - 1, pts);
  endtask

  // One output beat from a lane, held for one cycle.
  task automatic lane_out(input logic [1:0] ov, input logic [1:0] oe);
    lane_out_valid = ov; lane_out_eop = oe;
    @(posedge clk); #1;
    lane_out_valid = 2'b00; lane_out_eop = 2'b00;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, n1, bad, good, errs;
    logic [24:0] act_v, exp_v;

    //            v    s    e    pts    ov     oe     sr   rdy  swi  swo  lv     ls     le     lsr    srcv dpo    err
    tbl[0]  = '{1'b0,1'b0,1'b0,12'd0,2'b00,2'b00,1'b0,1'b1,1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,1'b0,12'd0,1'b0};
    tbl[1]  = '{1'b1,1'b1,1'b0,12'd2,2'b00,2'b00,1'b0,1'b1,1'b0,1'b0,2'b01,2'b01,2'b00,2'b00,1'b0,12'd0,1'b0};
    tbl[2]  = '{1'b1,1'b0,1'b1,12'd0,2'b00,2'b00,1'b0,1'b1,1'b0,1'b0,2'b01,2'b00,2'b01,2'b00,1'b0,12'd2,1'b0};
    tbl[3]  = '{1'b1,1'b1,1'b0,12'd3,2'b00,2'b00,1'b0,1'b1,1'b1,1'b0,2'b10,2'b10,2'b00,2'b00,1'b0,12'd2,1'b0};
    tbl[4]  = '{1'b1,1'b0,1'b0,12'd0,2'b01,2'b00,1'b1,1'b1,1'b1,1'b0,2'b10,2'b00,2'b00,2'b01,1'b1,12'd2,1'b0};
    tbl[5]  = '{1'b1,1'b0,1'b1,12'd0,2'b01,2'b01,1'b1,1'b1,1'b1,1'b0,2'b10,2'b00,2'b10,2'b01,1'b1,12'd2,1'b0};
    tbl[6]  = '{1'b0,1'b0,1'b0,12'd0,2'b01,2'b01,1'b1,1'b1,1'b0,1'b1,2'b00,2'b00,2'b00,2'b10,1'b0,12'd3,1'b0};
    tbl[7]  = '{1'b1,1'b1,1'b1,12'd1,2'b00,2'b00,1'b0,1'b1,1'b0,1'b1,2'b01,2'b01,2'b01,2'b00,1'b0,12'd3,1'b0};
    tbl[8]  = '{1'b0,1'b0,1'b0,12'd0,2'b00,2'b00,1'b0,1'b0,1'b1,1'b1,2'b00,2'b00,2'b00,2'b00,1'b0,12'd3,1'b0};
    tbl[9]  = '{1'b1,1'b1,1'b0,12'd5,2'b10,2'b10,1'b0,1'b0,1'b1,1'b1,2'b00,2'b00,2'b00,2'b00,1'b1,12'd3,1'b0};
    tbl[10] = '{1'b1,1'b1,1'b0,12'd5,2'b10,2'b10,1'b1,1'b0,1'b1,1'b1,2'b00,2'b00,2'b00,2'b10,1'b1,12'd3,1'b0};
    tbl[11] = '{1'b1,1'b1,1'b0,12'd5,2'b00,2'b00,1'b0,1'b1,1'b1,1'b0,2'b10,2'b10,2'b00,2'b00,1'b0,12'd1,1'b0};
    tbl[12] = '{1'b1,1'b0,1'b1,12'd0,2'b00,2'b00,1'b0,1'b1,1'b1,1'b0,2'b10,2'b00,2'b10,2'b00,1'b0,12'd1,1'b0};
    tbl[13] = '{1'b0,1'b0,1'b0,12'd0,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,1'b0,12'd1,1'b1};
    tbl[14] = '{1'b0,1'b0,1'b0,12'd0,2'b01,2'b01,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,2'b01,1'b1,12'd1,1'b0};
    tbl[15] = '{1'b1,1'b0,1'b0,12'd0,2'b00,2'b00,1'b0,1'b1,1'b0,1'b1,2'b00,2'b00,2'b00,2'b00,1'b0,12'd5,1'b0};
    tbl[16] = '{1'b0,1'b0,1'b0,12'd0,2'b00,2'b00,1'b0,1'b1,1'b0,1'b1,2'b00,2'b00,2'b00,2'b00,1'b0,12'd5,1'b1};
    tbl[17] = '{1'b0,1'b0,1'b0,12'd0,2'b00,2'b00,1'b0,1'b1,1'b0,1'b1,2'b00,2'b00,2'b00,2'b00,1'b0,12'd5,1'b0};

    // Reset values
    do_reset();
    chk("rst_dftpts0", lane_dftpts_0, 12'd0);
    chk("rst_dftpts1", lane_dftpts_1, 12'd0);
    chk("rst_sw", {sw_in, sw_out, frame_err, sink_ready}, 4'b0001);

    // Cycle-by-cycle vector table
    for (int i = 0; i < 18; i++) begin
      sink_valid = tbl[i].v; sink_sop = tbl[i].s; sink_eop = tbl[i].e; dftpts_in = tbl[i].pts;
      lane_out_valid = tbl[i].ov; lane_out_eop = tbl[i].oe; source_ready = tbl[i].sr;
      @(negedge clk);
      act_v = {sink_ready, sw_in, sw_out, lane_valid, lane_sop, lane_eop,
               lane_source_ready, source_valid, dftpts_out, frame_err};
      exp_v = {tbl[i].rdy, tbl[i].swi, tbl[i].swo, tbl[i].lv, tbl[i].ls, tbl[i].le,
               tbl[i].lsr, tbl[i].srcv, tbl[i].dpo, tbl[i].err};
      chk($sformatf("vec%0d", i), act_v, exp_v);
      @(posedge clk); #1;
    end

    // Two back-to-back 12-point frames, lanes echo 20 cycles later
    do_reset();
    source_ready = 1'b1;
    n0 = 0; n1 = 0; bad = 0;
    for (int f = 0; f < 2; f++) begin
      for (int b = 0; b < 12; b++) begin
        sink_valid = 1'b1; sink_sop = (b == 0); sink_eop = (b == 11); dftpts_in = 12'd12;
        @(negedge clk);
        if (lane_valid == 2'b01) n0++;
        else if (lane_valid == 2'b10) n1++;
        else bad++;
        if (lane_valid != (f == 0 ? 2'b01 : 2'b10)) bad++;
        @(posedge clk); #1;
      end
      chk($sformatf("a_swin_after_f%0d", f), sw_in, (f == 0) ? 1'b1 : 1'b0);
    end
    sink_valid = 1'b0; sink_sop = 1'b0; sink_eop = 1'b0;
    chk("a_lane0_beats", n0, 12);
    chk("a_lane1_beats", n1, 12);
    chk("a_misrouted", bad, 0);
    repeat (20) @(posedge clk);
    #1;
    lane_out(2'b10, 2'b10);
    chk("a_lane1_early_ignored", sw_out, 1'b0);
    good = 0;
    for (int b = 0; b < 12; b++) begin
      lane_out_valid = 2'b01; lane_out_eop = (b == 11) ? 2'b01 : 2'b00;
      @(negedge clk);
      if (source_valid && dftpts_out == 12'd12 && !sw_out) good++;
      @(posedge clk); #1;
    end
    chk("a_out_lane0", good, 12);
    chk("a_swout_after0", sw_out, 1'b1);
    good = 0;
    for (int b = 0; b < 12; b++) begin
      lane_out_valid = 2'b10; lane_out_eop = (b == 11) ? 2'b10 : 2'b00;
      @(negedge clk);
      if (source_valid && dftpts_out == 12'd12 && sw_out) good++;
      @(posedge clk); #1;
    end
    lane_out_valid = 2'b00; lane_out_eop = 2'b00;
    chk("a_out_lane1", good, 12);
    chk("a_swout_after1", sw_out, 1'b0);

    // Back-pressure with three frames while lane 0 is not drained
    do_reset();
    source_ready = 1'b1;
    fwd_beats = 0;
    send_frame(12'd3, 3);
    send_frame(12'd3, 3);
    sink_valid = 1'b1; sink_sop = 1'b1; sink_eop = 1'b0; dftpts_in = 12'd4;
    bad = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (sink_ready || lane_valid != 2'b00) bad++;
      @(posedge clk); #1;
    end
    chk("b_held_off", bad, 0);
    lane_out_valid = 2'b01; lane_out_eop = 2'b01;
    @(negedge clk);
    chk("b_rdy_on_release_cycle", sink_ready, 1'b0);
    @(posedge clk); #1;
    lane_out_valid = 2'b00; lane_out_eop = 2'b00;
    @(negedge clk);
    chk("b_rdy_after_release", {sink_ready, lane_valid, lane_sop}, 5'b10101);
    if (lane_valid != 2'b00) fwd_beats++;
    @(posedge clk); #1;
    drive_beat(1'b0, 1'b0, 12'd4);
    drive_beat(1'b0, 1'b0, 12'd4);
    drive_beat(1'b0, 1'b1, 12'd4);
    chk("b_no_beats_lost", fwd_beats, 10);
    chk("b_frame3_size", lane_dftpts_0, 12'd4);
    @(negedge clk);
    chk("b_no_len_err", frame_err, 1'b0);
    @(posedge clk); #1;

    // 24-point frame closed on beat 23, then a size-0 frame
    do_reset();
    source_ready = 1'b1;
    send_frame(12'd24, 23);
    @(negedge clk);
    chk("c_err_pulse", frame_err, 1'b1);
    errs = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1; @(negedge clk);
      if (frame_err) errs++;
    end
    chk("c_err_single", errs, 0);
    chk("c_committed", {sw_in, dftpts_out}, {1'b1, 12'd24});
    @(posedge clk); #1;
    lane_out(2'b01, 2'b01);
    chk("c_lane_was_proc", sw_out, 1'b1);
    send_frame(12'd0, 1);
    @(negedge clk);
    chk("c_size0_err", {frame_err, sw_in}, 2'b10);
    @(posedge clk); #1;

    // Restart: second sop on beat 5, size re-latched to 36
    do_reset();
    source_ready = 1'b1;
    for (int b = 0; b < 4; b++) drive_beat(b == 0, 1'b0, 12'd12);
    drive_beat(1'b1, 1'b0, 12'd36);
    chk("d_sop_forwarded", {last_lv, last_ls}, 4'b0101);
    @(negedge clk);
    chk("d_restart_err", {frame_err, sw_in, dftpts_out}, {1'b1, 1'b0, 12'd36});
    @(posedge clk); #1;
    for (int b = 0; b < 35; b++) drive_beat(1'b0, b == 34, 12'd36);
    @(negedge clk);
    chk("d_count_restarted", {frame_err, sw_in}, 2'b01);
    @(posedge clk); #1;

    // Asynchronous reset mid-frame with lane 1 in PROC
    do_reset();
    source_ready = 1'b1;
    send_frame(12'd2, 2);
    send_frame(12'd2, 2);
    lane_out(2'b01, 2'b01);
    drive_beat(1'b1, 1'b0, 12'd7);
    chk("f_pre_reset", {sw_in, sw_out, dftpts_out}, {1'b0, 1'b1, 12'd2});
    lane_out_valid = 2'b10;
    sink_valid = 1'b1;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("f_async_clear", {sw_in, sw_out, source_valid, frame_err, sink_ready, lane_valid},
        7'b0000100);
    chk("f_async_sizes", {lane_dftpts_0, lane_dftpts_1, dftpts_out}, 36'd0);
    lane_out_valid = 2'b00;
    sink_valid = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    drive_beat(1'b1, 1'b0, 12'd9);
    chk("f_next_sop_lane0", last_lv, 2'b01);
    chk("f_size_latched", dftpts_out, 12'd9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
